// File: rtl/sinc_mclk_sequencer_if.sv
// sinc_mclk_sequencer_if: configuration bus from the register bank to the MCLK/decimation sequencer
interface sinc_mclk_sequencer_if #(
   parameter int DIV_W = 16,
   parameter int DEC_W = 10
);
   logic [DIV_W-1:0] cfg_mdiv;
   logic [DEC_W-1:0] cfg_dec;
   logic             cfg_load;
   logic             cfg_busy;
   modport master (output cfg_mdiv, cfg_dec, cfg_load, input cfg_busy);
   modport slave (input cfg_mdiv, cfg_dec, cfg_load, output cfg_busy);
endinterface

// File: rtl/sinc_mclk_sequencer.sv
// sinc_mclk_sequencer: modulator clock, bit strobes, decimation ticks, settling and glitch-free reconfiguration
module sinc_mclk_sequencer #(
   parameter int DIV_W = 16,
   parameter int DEC_W = 10,
   parameter int SETTLE_TICKS = 3
) (
   input  logic                 sys_clk,
   input  logic                 reset_n,
   input  logic                 enable,
   sinc_mclk_sequencer_if.slave cfg,
   output logic                 mclk,
   output logic                 bit_strobe,
   output logic                 dec_tick,
   output logic                 data_valid,
   output logic                 flush,
   output logic                 state_run
);
   localparam int SW = SETTLE_TICKS > 0 ? $clog2(SETTLE_TICKS + 1) : 1;
   localparam logic [SW-1:0] SETTLE_INIT = SW'(SETTLE_TICKS);
   typedef enum logic [1:0] {IDLE, SETTLE, RUN} state_t;
   state_t state_q, state_d;
   logic [DIV_W-1:0] half_q, half_d, mdiv_act_q, mdiv_act_d, mdiv_sh_q, mdiv_sh_d, mdiv_m1;
   logic [DEC_W-1:0] bit_q, bit_d, dec_act_q, dec_act_d, dec_sh_q, dec_sh_d, dec_m1;
   logic [SW-1:0] settle_q, settle_d;
   logic mclk_q, mclk_d, bit_strobe_q, bit_strobe_d, dec_tick_q, dec_tick_d;
   logic data_valid_q, data_valid_d, flush_q, flush_d, busy_q, busy_d;
   logic wrap, apply;
   assign mdiv_m1 = (mdiv_act_q == '0 ? DIV_W'(1) : mdiv_act_q) - DIV_W'(1);
   assign dec_m1  = (dec_act_q == '0 ? DEC_W'(1) : dec_act_q) - DEC_W'(1);
   assign wrap    = half_q == mdiv_m1;
   assign apply   = wrap && mclk_q && busy_q;
   always_comb begin
      state_d      = state_q;
      half_d       = half_q;
      bit_d        = bit_q;
      settle_d     = settle_q;
      mclk_d       = mclk_q;
      bit_strobe_d = 1'b0;
      dec_tick_d   = 1'b0;
      data_valid_d = 1'b0;
      flush_d      = 1'b0;
      mdiv_act_d   = mdiv_act_q;
      dec_act_d    = dec_act_q;
      mdiv_sh_d    = mdiv_sh_q;
      dec_sh_d     = dec_sh_q;
      busy_d       = busy_q;
      if (!enable) begin
         state_d    = IDLE;
         half_d     = '0;
         bit_d      = '0;
         settle_d   = '0;
         mclk_d     = 1'b0;
         busy_d     = 1'b0;
         mdiv_act_d = cfg.cfg_load ? cfg.cfg_mdiv : busy_q ? mdiv_sh_q : mdiv_act_q;
         dec_act_d  = cfg.cfg_load ? cfg.cfg_dec : busy_q ? dec_sh_q : dec_act_q;
      end else if (state_q == IDLE) begin
         state_d    = SETTLE;
         flush_d    = 1'b1;
         settle_d   = SETTLE_INIT;
         mdiv_act_d = cfg.cfg_load ? cfg.cfg_mdiv : mdiv_act_q;
         dec_act_d  = cfg.cfg_load ? cfg.cfg_dec : dec_act_q;
      end else begin
         half_d       = wrap ? '0 : half_q + DIV_W'(1);
         mclk_d       = wrap ? !mclk_q : mclk_q;
         bit_strobe_d = wrap && !mclk_q;
         dec_tick_d   = bit_strobe_d && bit_q == dec_m1;
         data_valid_d = dec_tick_d && state_q == RUN;
         bit_d        = !bit_strobe_d ? bit_q : dec_tick_d ? '0 : bit_q + DEC_W'(1);
         if (state_q == SETTLE) begin
            if (settle_q == '0) state_d = RUN;
            else if (dec_tick_d) begin
               settle_d = settle_q - SW'(1);
               if (settle_q == SW'(1)) state_d = RUN;
            end
         end
         if (apply) begin
            mdiv_act_d = mdiv_sh_q;
            dec_act_d  = dec_sh_q;
            half_d     = '0;
            bit_d      = '0;
            flush_d    = 1'b1;
            settle_d   = SETTLE_INIT;
            state_d    = SETTLE;
            busy_d     = 1'b0;
         end
         if (cfg.cfg_load) begin
            mdiv_sh_d = cfg.cfg_mdiv;
            dec_sh_d  = cfg.cfg_dec;
            busy_d    = 1'b1;
         end
      end
   end
   always_ff @(posedge sys_clk or negedge reset_n)
      if (!reset_n) begin
         state_q      <= IDLE;
         half_q       <= '0;
         bit_q        <= '0;
         settle_q     <= '0;
         mclk_q       <= 1'b0;
         bit_strobe_q <= 1'b0;
         dec_tick_q   <= 1'b0;
         data_valid_q <= 1'b0;
         flush_q      <= 1'b0;
         mdiv_act_q   <= DIV_W'(1);
         dec_act_q    <= DEC_W'(1);
         mdiv_sh_q    <= '0;
         dec_sh_q     <= '0;
         busy_q       <= 1'b0;
      end else begin
         state_q      <= state_d;
         half_q       <= half_d;
         bit_q        <= bit_d;
         settle_q     <= settle_d;
         mclk_q       <= mclk_d;
         bit_strobe_q <= bit_strobe_d;
         dec_tick_q   <= dec_tick_d;
         data_valid_q <= data_valid_d;
         flush_q      <= flush_d;
         mdiv_act_q   <= mdiv_act_d;
         dec_act_q    <= dec_act_d;
         mdiv_sh_q    <= mdiv_sh_d;
         dec_sh_q     <= dec_sh_d;
         busy_q       <= busy_d;
      end
   assign mclk         = mclk_q;
   assign bit_strobe   = bit_strobe_q;
   assign dec_tick     = dec_tick_q;
   assign data_valid   = data_valid_q;
   assign flush        = flush_q;
   assign state_run    = state_q == RUN;
   assign cfg.cfg_busy = busy_q;
endmodule

// File: doc/sinc_mclk_sequencer.md
Name: sinc_mclk_sequencer

Overview:
- Sequences the sigma-delta modulator clock and the sinc decimation filter for one modulator channel group.
- Generates MCLK from sys_clk and issues per-bit sample strobes and decimation ticks.
- Handles start-up settling and flush and glitch-free divider/decimation reconfiguration.
- Sits between the register bank (configuration) and the sinc filter/trip datapath (consumes strobes).

Parameters:
- DIV_W, 16, width of half-period divider cfg_mdiv.
- DEC_W, 10, width of decimation ratio cfg_dec.
- SETTLE_TICKS, 3, decimation ticks discarded after start/reconfig (sinc3 group delay).

Ports:
- sys_clk  in  1  system clock; all logic on posedge.
- reset_n  in  1  asynchronous active-low reset.
- enable  in  1  level; 1 = run sequencer, 0 = stop and return to IDLE.
- cfg_mdiv  in  DIV_W  MCLK half-period in sys_clk cycles; 0 treated as 1.
- cfg_dec  in  DEC_W  MCLK rising edges per decimation tick; 0 treated as 1.
- cfg_load  in  1  one-cycle pulse; capture cfg_mdiv/cfg_dec.
- cfg_busy  out  1  high while a captured config is pending application.
- mclk  out  1  modulator clock output, registered.
- bit_strobe  out  1  one-cycle pulse in the cycle mclk first reads 1 (modulator data sample point).
- dec_tick  out  1  one-cycle pulse every cfg_dec bit_strobes (filter output point).
- data_valid  out  1  dec_tick qualified by state RUN.
- flush  out  1  one-cycle pulse; sinc integrators/differentiators must clear.
- state_run  out  1  high in RUN.

Behaviour:
- Reset (async, reset_n=0): all outputs 0; counters 0; active cfg = mdiv 1, dec 1; state IDLE.
- States: IDLE, SETTLE, RUN.
- IDLE:
  - mclk held 0; all counters held 0.
  - cfg_load applies cfg immediately to active registers; cfg_busy stays 0.
  - enable=1: next cycle pulse flush, load settle counter = SETTLE_TICKS, go to SETTLE.
- MCLK generation (SETTLE/RUN):
  - Half counter runs 0..mdiv_act-1; at mdiv_act-1 it wraps to 0 and mclk toggles.
  - Period = 2*mdiv_act sys_clk cycles, 50% duty.
  - mdiv_act=1 gives mclk = sys_clk/2.
  - bit_strobe is asserted in the same cycle mclk becomes 1 (registered together with mclk).
- Decimation:
  - Bit counter increments on each bit_strobe, 0..dec_act-1.
  - dec_tick is asserted together with the bit_strobe that wraps the counter to 0.
  - dec_act=1 gives dec_tick == bit_strobe.
- SETTLE:
  - Each dec_tick decrements the settle counter; data_valid stays 0.
  - On the dec_tick that reaches 0, go to RUN.
  - The next dec_tick is the first data_valid.
  - SETTLE_TICKS=0 enters RUN one cycle after the flush pulse.
- RUN: data_valid = dec_tick; state_run=1.
- Reconfiguration:
  - cfg_load in SETTLE/RUN captures cfg into shadow registers; cfg_busy=1 from the next cycle.
  - Apply at the next mclk falling toggle (1->0), never mid-phase, so there is no runt pulse.
  - On apply: active cfg <- shadow; half and bit counters cleared; flush pulse; settle counter reloaded; state SETTLE; cfg_busy cleared.
  - A second cfg_load while busy overwrites the shadow; only the latest is applied.
  - cfg_load in the same cycle as the apply toggle is captured after the apply; cfg_busy stays/returns to 1.
- enable=0 in any state:
  - Next cycle: state IDLE, mclk 0, counters cleared, bit_strobe/dec_tick/data_valid 0.
  - A pending shadow is applied to active and cfg_busy cleared.
  - No flush on stop.
- Simultaneous enable rise and cfg_load in IDLE: new cfg is used for the first MCLK period.
- Mid-operation reset: outputs go to reset values asynchronously; restart requires the enable sequence again.
- Counter widths: no overflow possible; compares against (value-1) are done in DIV_W/DEC_W bits with 0 mapped to 1 before subtraction.

Test Plan:
- Reset/start: cfg_mdiv=4, cfg_dec=8, enable=1 -> one flush pulse; mclk period 8 cycles, duty 4/4; first 3 dec_ticks with data_valid=0, 4th dec_tick data_valid=1, state_run=1.
- Boundary values: cfg_mdiv=0 and cfg_mdiv=1 -> mclk toggles every cycle; cfg_dec=0 -> dec_tick coincides with every bit_strobe.
- Mid-run reconfig: in RUN with mdiv=4, cfg_load with mdiv=10 while mclk high -> cfg_busy=1; mclk finishes its high phase (4 cycles); apply at the fall with flush; the low phase is then 10 cycles; 3 settle ticks precede data_valid.
- Double load: two cfg_loads (mdiv=6 then mdiv=3) before the fall -> only mdiv=3 applied; single flush.
- Stop: enable=0 mid-high-phase -> mclk 0 the next cycle, no flush, state_run=0; re-enable -> flush and full settle repeated.
- Async reset: reset_n low between clock edges during RUN -> all outputs 0 immediately; active cfg mdiv=1, dec=1 after release.
